// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared constants for the multi-port register file: default
//             geometry, write-port indices and the address-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int N_DEF     = 32;
    localparam int DEPTH_DEF = 32;
    localparam int NRD_DEF   = 2;

    // Write-port indices. The higher index wins on an address collision,
    // so the load-return port must keep the larger index.
    localparam int WR0_IDX = 0;
    localparam int WR1_IDX = 1;
    localparam int NWR     = 2;

    // Address width for a register file of the given depth (minimum 1 bit)
    function automatic int calc_aw(input int depth);
        int aw;
        aw = 1;
        for (int i = 1; i < 7; i++) begin
            if ((1 << aw) < depth) begin
                aw = aw + 1;
            end
        end
        return aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Purpose  : One busy bit per register. Alloc sets a bit, a write clears it,
//             alloc wins when both hit the same register. Provides NRD
//             registered lookups of the busy bit at the read addresses.
//  Config   : REGFILE_BYPASS_EN - lookups observe the post-edge busy state
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_alloc_en,
    input  logic [AW-1:0]     i_alloc_addr,
    input  logic [NWR-1:0]    i_clr_en,
    input  logic [NWR*AW-1:0] i_clr_addr,
    input  logic [NRD-1:0]    i_rd_en,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_rd_busy
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic [DEPTH-1:0] w_busy_src;
    logic [NRD-1:0]   w_lookup;
    logic [NRD-1:0]   r_rd_busy;

    // Next busy state: clears first, then alloc overrides; r0 never busy
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 1; i < DEPTH; i++) begin
            for (int p = 0; p < NWR; p++) begin
                if (i_clr_en[p] && (i_clr_addr[p*AW +: AW] == AW'(i))) begin
                    w_busy_next[i] = 1'b0;
                end
            end
            if (i_alloc_en && (i_alloc_addr == AW'(i))) begin
                w_busy_next[i] = 1'b1;
            end
        end
        w_busy_next[0] = 1'b0;
    end

`ifdef REGFILE_BYPASS_EN
    assign w_busy_src = w_busy_next;
`else
    assign w_busy_src = r_busy;
`endif

    // Per-port lookup; addresses beyond DEPTH match nothing and read 0
    always_comb begin
        w_lookup = '0;
        for (int k = 0; k < NRD; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_rd_addr[k*AW +: AW] == AW'(i)) begin
                    w_lookup[k] = w_busy_src[i];
                end
            end
        end
    end

    // Busy array and registered per-port lookup (held when port disabled)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_rd_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
            for (int k = 0; k < NRD; k++) begin
                if (i_rd_en[k]) begin
                    r_rd_busy[k] <= w_lookup[k];
                end
            end
        end
    end

    assign o_rd_busy = r_rd_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port register file, NRD registered read ports, two write
//             ports (wr0 = ALU, wr1 = load return, wr1 wins on collision),
//             with a per-register busy scoreboard. r0 is hardwired to zero.
//  Config   : REGFILE_BYPASS_EN - same-cycle reads return post-edge state
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW   = calc_aw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*N-1:0]  rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic [N-1:0]      wr0_data,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [N-1:0]      wr1_data,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr
);

    logic [N-1:0]      r_regs      [DEPTH];
    logic [N-1:0]      w_regs_next [DEPTH];
    logic [N-1:0]      w_regs_src  [DEPTH];
    logic [NWR-1:0]    w_wr_en;
    logic [NWR*AW-1:0] w_wr_addr;
    logic [N-1:0]      w_wr_data   [NWR];
    logic [NRD*N-1:0]  w_rd_val;
    logic [NRD*N-1:0]  r_rd_data;

    assign w_wr_en[WR0_IDX]             = wr0_en;
    assign w_wr_en[WR1_IDX]             = wr1_en;
    assign w_wr_addr[WR0_IDX*AW +: AW]  = wr0_addr;
    assign w_wr_addr[WR1_IDX*AW +: AW]  = wr1_addr;
    assign w_wr_data[WR0_IDX]           = wr0_data;
    assign w_wr_data[WR1_IDX]           = wr1_data;

    // Next register contents; ports applied in index order so wr1 wins
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_regs_next[i] = r_regs[i];
        end
        for (int i = 1; i < DEPTH; i++) begin
            for (int p = 0; p < NWR; p++) begin
                if (w_wr_en[p] && (w_wr_addr[p*AW +: AW] == AW'(i))) begin
                    w_regs_next[i] = w_wr_data[p];
                end
            end
        end
        w_regs_next[0] = '0;
    end

    // Read source: post-edge contents with bypass, stored contents without
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef REGFILE_BYPASS_EN
            w_regs_src[i] = w_regs_next[i];
`else
            w_regs_src[i] = r_regs[i];
`endif
        end
    end

    // Read mux per port; out-of-range addresses return 0
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NRD; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_addr[k*AW +: AW] == AW'(i)) begin
                    w_rd_val[k*N +: N] = w_regs_src[i];
                end
            end
        end
    end

    // Register array and registered read data (held when port disabled)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= w_regs_next[i];
            end
            for (int k = 0; k < NRD; k++) begin
                if (rd_en[k]) begin
                    r_rd_data[k*N +: N] <= w_rd_val[k*N +: N];
                end
            end
        end
    end

    assign rd_data = r_rd_data;

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_alloc_en   (alloc_en),
        .i_alloc_addr (alloc_addr),
        .i_clr_en     (w_wr_en),
        .i_clr_addr   (w_wr_addr),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .o_rd_busy    (rd_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp (N=32, DEPTH=24, NRD=2)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int N     = 32;
    localparam int DEPTH = 24;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*N-1:0]  rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wr0_en, wr1_en, alloc_en;
    logic [AW-1:0]     wr0_addr, wr1_addr, alloc_addr;
    logic [N-1:0]      wr0_data, wr1_data;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: architectural contents and busy bits per address
    logic [N-1:0] m_mem  [32];
    bit           m_busy [32];
    logic [N-1:0] exp_data [NRD];
    logic         exp_busy [NRD];

    regfile_mp #(.N(N), .DEPTH(DEPTH), .NRD(NRD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: apply the cycle's operations in priority order
    always @(posedge clk) begin
        logic [N-1:0] nm [32];
        bit           nb [32];
        int           a;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            for (int k = 0; k < NRD; k++) begin
                exp_data[k] = '0;
                exp_busy[k] = 1'b0;
            end
        end else begin
            nm = m_mem;
            nb = m_busy;
            if (wr0_en && wr0_addr != 0 && int'(wr0_addr) < DEPTH) begin
                nm[wr0_addr] = wr0_data;
                nb[wr0_addr] = 1'b0;
            end
            if (wr1_en && wr1_addr != 0 && int'(wr1_addr) < DEPTH) begin
                nm[wr1_addr] = wr1_data;
                nb[wr1_addr] = 1'b0;
            end
            if (alloc_en && alloc_addr != 0 && int'(alloc_addr) < DEPTH) begin
                nb[alloc_addr] = 1'b1;
            end
            for (int k = 0; k < NRD; k++) begin
                if (rd_en[k]) begin
                    a = int'(rd_addr[k*AW +: AW]);
                    if (a == 0 || a >= DEPTH) begin
                        exp_data[k] = '0;
                        exp_busy[k] = 1'b0;
                    end else if (BYP) begin
                        exp_data[k] = nm[a];
                        exp_busy[k] = nb[a];
                    end else begin
                        exp_data[k] = m_mem[a];
                        exp_busy[k] = m_busy[a];
                    end
                end
            end
            m_mem  = nm;
            m_busy = nb;
        end
    end

    // Every-cycle comparison of both read ports against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("model_rd_data%0d", k), 64'(rd_data[k*N +: N]), 64'(exp_data[k]));
                check($sformatf("model_rd_busy%0d", k), 64'(rd_busy[k]), 64'(exp_busy[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        rd_en      = '0;
        rd_addr    = '0;
        wr0_en     = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en     = 1'b0; wr1_addr = '0; wr1_data = '0;
        alloc_en   = 1'b0; alloc_addr = '0;
    endtask

    task automatic wr0(input int a, input logic [N-1:0] d);
        wr0_en = 1'b1; wr0_addr = AW'(a); wr0_data = d;
    endtask

    task automatic wr1(input int a, input logic [N-1:0] d);
        wr1_en = 1'b1; wr1_addr = AW'(a); wr1_data = d;
    endtask

    task automatic alloc(input int a);
        alloc_en = 1'b1; alloc_addr = AW'(a);
    endtask

    task automatic rd(input int k, input int a);
        rd_en[k] = 1'b1;
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_rd_data", 64'(rd_data), 64'h0);
        check("reset_rd_busy", 64'(rd_busy), 64'h0);
        rst = 1'b0;

        // Reset wipes a previously written register
        wr0(5, 32'hDEADBEEF); tick();
        clr(); rst = 1'b1; tick(); tick(); rst = 1'b0;
        rd(0, 5); tick();
        check("reset_r5_data", 64'(rd_data[31:0]), 64'h0);
        check("reset_r5_busy", 64'(rd_busy[0]), 64'h0);

        // Basic write then read; r0 stays zero
        clr(); wr0(3, 32'h12345678); tick();
        clr(); rd(0, 3); tick();
        check("wr_rd_r3", 64'(rd_data[31:0]), 64'h12345678);
        clr(); wr0(0, 32'hFFFFFFFF); tick();
        clr(); rd(1, 0); tick();
        check("r0_zero", 64'(rd_data[63:32]), 64'h0);

        // Same-cycle write collision: load return wins
        clr(); wr0(7, 32'h1111); wr1(7, 32'h2222); tick();
        clr(); rd(0, 7); tick();
        check("collision_r7", 64'(rd_data[31:0]), 64'h2222);

        // Scoreboard set / clear / alloc-wins
        clr(); alloc(9); tick();
        clr(); rd(0, 9); tick();
        check("sb_alloc_busy", 64'(rd_busy[0]), 64'h1);
        clr(); wr1(9, 32'hAB); tick();
        clr(); rd(0, 9); tick();
        check("sb_clear_busy", 64'(rd_busy[0]), 64'h0);
        check("sb_clear_data", 64'(rd_data[31:0]), 64'hAB);
        clr(); alloc(9); wr0(9, 32'hCD); tick();
        clr(); rd(0, 9); rd(1, 9); tick();
        check("sb_alloc_wins", 64'(rd_busy[1]), 64'h1);
        check("sb_alloc_data", 64'(rd_data[63:32]), 64'hCD);
        clr(); alloc(0); tick();
        clr(); rd(0, 0); tick();
        check("sb_r0_never_busy", 64'(rd_busy[0]), 64'h0);

        // Read during write / alloc in the same cycle
        clr(); wr0(4, 32'h5); tick();
        clr(); wr0(4, 32'h9); rd(0, 4); alloc(4); rd(1, 4); tick();
        check("rdw_data", 64'(rd_data[31:0]), BYP ? 64'h9 : 64'h5);
        check("rdw_busy", 64'(rd_busy[1]), BYP ? 64'h1 : 64'h0);

        // Out-of-range read and hold with rd_en low
        clr(); wr0(30, 32'h3030); alloc(30); tick();
        clr(); rd(0, 30); tick();
        check("range_r30_data", 64'(rd_data[31:0]), 64'h0);
        check("range_r30_busy", 64'(rd_busy[0]), 64'h0);
        clr(); wr0(1, 32'h77); tick();
        clr(); rd(0, 1); tick();
        check("hold_initial", 64'(rd_data[31:0]), 64'h77);
        clr(); wr0(1, 32'h88); alloc(1); tick();
        check("hold_1", 64'(rd_data[31:0]), 64'h77);
        check("hold_busy", 64'(rd_busy[0]), 64'h0);
        clr(); tick();
        check("hold_2", 64'(rd_data[31:0]), 64'h77);

        // Reset discards operations issued in the same cycle
        clr(); rst = 1'b1; wr0(2, 32'h55); alloc(2); rd(0, 3); tick();
        check("rst_discard_rd", 64'(rd_data[31:0]), 64'h0);
        rst = 1'b0;
        clr(); rd(0, 2); rd(1, 3); tick();
        check("rst_discard_wr", 64'(rd_data[31:0]), 64'h0);
        check("rst_discard_alloc", 64'(rd_busy[0]), 64'h0);
        check("rst_r3_cleared", 64'(rd_data[63:32]), 64'h0);

        // Directed mixed traffic, checked against the model every cycle
        for (int i = 0; i < 40; i++) begin
            clr();
            wr0((i * 7) % 26, 32'h01010101 * i);
            if (i % 3 == 0) wr1((i * 5) % 26, ~(32'(i)));
            if (i % 4 == 1) alloc((i * 3) % 26);
            rd(0, (i * 11) % 26);
            if (i % 5 != 2) rd(1, (i + 3) % 26);
            tick();
        end
        clr(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
